// File: rtl/aes_128_pkg.sv
// AES-128 shared definitions: state encoding, schedule constants,
// round-constant lookup and the FIPS-197 S-box table.
package aes_128_pkg;

    localparam int NR       = 10;
    localparam int NK_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    // RCON[1..10]; index 0 and 11..15 are never used.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Entry 0 sits in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/aes_128_sbox_word.sv
// Four S-box ROMs on one 32-bit word with a registered output.
// Ports: clk, rst (async high), en_i (capture), word_i, word_o.
module aes_128_sbox_word
    import aes_128_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    logic [31:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else if (en_i) begin
            word_q <= {sub_byte(word_i[31:24]),
                       sub_byte(word_i[23:16]),
                       sub_byte(word_i[15:8]),
                       sub_byte(word_i[7:0])};
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/aes_128_key_expand_4cyc.sv
// AES-128 key schedule: expands key_in into rk[0..10] at 4 cycles per
// round key and serves them on key_round, stepping on key_ready.
// Ports: clk, kill (async high reset), key_in, key_load, blk_start,
//   key_ready in; key_round, key_valid, busy,
//   key_load_collision_irq_pulse out.
module aes_128_key_expand_4cyc
    import aes_128_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         kill,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         blk_start,
    input  logic         key_ready,
    output logic [127:0] key_round,
    output logic         key_valid,
    output logic         busy,
    output logic         key_load_collision_irq_pulse
);

    // Phase in which the S-box result is consumed.
    localparam logic [1:0] PH_SUB = 2'(SBOX_LAT);

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [1:0]   ph_q, ph_d;
    logic [31:0]  n0_q, n0_d;
    logic [31:0]  n1_q, n1_d;
    logic [3:0]   ptr_q, ptr_d;
    logic [127:0] kr_q, kr_d;
    logic         irq_q;
    logic [127:0] rk_q [0:NR];

    logic         rk_we;
    logic [3:0]   rk_wa;
    logic [127:0] rk_wd;
    logic         sbox_en;
    logic [31:0]  sub_w;
    logic [127:0] prev;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  n2, n3;
    logic [3:0]   ptr_next;

    assign prev = rk_q[rnd_q - 4'd1];
    assign w0   = prev[127:96];
    assign w1   = prev[95:64];
    assign w2   = prev[63:32];
    assign w3   = prev[31:0];
    assign n2   = w2 ^ n1_q;
    assign n3   = w3 ^ n2;

    aes_128_sbox_word u_sbox (
        .clk    (clk),
        .rst    (kill),
        .en_i   (sbox_en),
        .word_i ({w3[23:0], w3[31:24]}),
        .word_o (sub_w)
    );

    // blk_start outranks key_ready; ptr wraps 10 -> 0.
    always_comb begin
        ptr_next = ptr_q;
        if (blk_start) begin
            ptr_next = '0;
        end else if (key_ready) begin
            if (ptr_q == 4'(NR)) begin
                ptr_next = '0;
            end else begin
                ptr_next = ptr_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        ph_d    = ph_q;
        n0_d    = n0_q;
        n1_d    = n1_q;
        ptr_d   = ptr_q;
        kr_d    = kr_q;
        rk_we   = 1'b0;
        rk_wa   = '0;
        rk_wd   = '0;
        sbox_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ptr_d = '0;
                if (key_load) begin
                    rk_we   = 1'b1;
                    rk_wd   = key_in;
                    rnd_d   = 4'd1;
                    ph_d    = 2'd0;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                ptr_d = '0;
                // 2-bit phase wraps 3 -> 0 on its own.
                ph_d  = ph_q + 2'd1;
                if (ph_q == 2'd0) begin
                    sbox_en = 1'b1;
                end else if (ph_q == PH_SUB) begin
                    n0_d = w0 ^ sub_w ^ {rcon(rnd_q), 24'h0};
                end else if (ph_q == 2'd2) begin
                    n1_d = w1 ^ n0_q;
                end else begin
                    rk_we = 1'b1;
                    rk_wa = rnd_q;
                    rk_wd = {n0_q, n1_q, n2, n3};
                    if (rnd_q == 4'(NR)) begin
                        state_d = ST_READY;
                        kr_d    = rk_q[0];
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            ST_READY: begin
                if (key_load) begin
                    rk_we   = 1'b1;
                    rk_wd   = key_in;
                    rnd_d   = 4'd1;
                    ph_d    = 2'd0;
                    ptr_d   = '0;
                    state_d = ST_EXPAND;
                end else begin
                    ptr_d = ptr_next;
                    kr_d  = rk_q[ptr_next];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            ph_q    <= '0;
            n0_q    <= '0;
            n1_q    <= '0;
            ptr_q   <= '0;
            kr_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            ph_q    <= ph_d;
            n0_q    <= n0_d;
            n1_q    <= n1_d;
            ptr_q   <= ptr_d;
            kr_q    <= kr_d;
            irq_q   <= key_load && (state_q == ST_EXPAND);
        end
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else if (rk_we) begin
            rk_q[rk_wa] <= rk_wd;
        end
    end

    assign key_round = kr_q;
    assign key_valid = (state_q == ST_READY);
    assign busy      = (state_q == ST_EXPAND);
    assign key_load_collision_irq_pulse = irq_q;

endmodule

// File: tb/tb_aes_128_key_expand_4cyc.sv
// Directed bench for aes_128_key_expand_4cyc using FIPS-197 vectors.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_aes_128_key_expand_4cyc;

    localparam logic [127:0] A_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_K2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         kill;
    logic [127:0] key_in;
    logic         key_load;
    logic         blk_start;
    logic         key_ready;
    logic [127:0] key_round;
    logic         key_valid;
    logic         busy;
    logic         irq;

    int checks   = 0;
    int failures = 0;

    aes_128_key_expand_4cyc #(.SBOX_LAT(1)) dut (
        .clk                          (clk),
        .kill                         (kill),
        .key_in                       (key_in),
        .key_load                     (key_load),
        .blk_start                    (blk_start),
        .key_ready                    (key_ready),
        .key_round                    (key_round),
        .key_valid                    (key_valid),
        .busy                         (busy),
        .key_load_collision_irq_pulse (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int n);
        key_ready = 1'b1;
        repeat (n) tick();
        key_ready = 1'b0;
    endtask

    // Returns the cycle offset (from the key_load cycle) at which
    // key_valid is first seen; 60 means it never rose.
    task automatic load_wait(input logic [127:0] k, output int lat);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        lat = 1;
        chk("busy_t1", busy, 1);
        chk("valid_t1", key_valid, 0);
        chk("irq_t1", irq, 0);
        while (!key_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        kill      = 1'b0;
        key_in    = '0;
        key_load  = 1'b0;
        blk_start = 1'b0;
        key_ready = 1'b0;
        #1 kill = 1'b1;
        tick();
        tick();
        kill = 1'b0;
        tick();

        chk("rst_valid", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_round", key_round, 0);
        chk("rst_irq", irq, 0);

        // FIPS-197 A.1
        load_wait(A_K0, lat);
        chk("a1_latency", 128'(lat), 41);
        chk("a1_busy_rdy", busy, 0);
        chk("a1_rk0", key_round, A_K0);
        strobe(1);
        chk("a1_rk1", key_round, A_K1);
        strobe(1);
        chk("a1_rk2", key_round, A_K2);
        strobe(8);
        chk("a1_rk10", key_round, A_K10);

        // Wrap and rewind
        strobe(1);
        chk("wrap_rk0", key_round, A_K0);
        strobe(5);
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        chk("blk_rk0", key_round, A_K0);
        strobe(3);
        blk_start = 1'b1;
        key_ready = 1'b1;
        tick();
        blk_start = 1'b0;
        key_ready = 1'b0;
        chk("both_rk0", key_round, A_K0);
        strobe(1);
        chk("after_both_rk1", key_round, A_K1);

        // Collision: second key_load at T+10 is ignored
        key_in    = A_K0;
        key_load  = 1'b1;
        key_ready = 1'b1;
        tick();
        key_load  = 1'b0;
        key_ready = 1'b0;
        lat = 1;
        chk("col_valid_drop", key_valid, 0);
        chk("col_busy", busy, 1);
        while (!key_valid && lat < 60) begin
            if (lat == 10) begin
                key_in   = B_K0;
                key_load = 1'b1;
            end
            tick();
            key_load = 1'b0;
            lat++;
            if (lat == 11) chk("col_irq_hi", irq, 1);
            if (lat == 12) chk("col_irq_lo", irq, 0);
        end
        chk("col_latency", 128'(lat), 41);
        chk("col_rk0", key_round, A_K0);
        strobe(10);
        chk("col_rk10", key_round, A_K10);

        // Rekey from READY
        load_wait(B_K0, lat);
        chk("rekey_latency", 128'(lat), 41);
        chk("rekey_rk0", key_round, B_K0);
        strobe(10);
        chk("rekey_rk10", key_round, B_K10);

        // Kill mid-expansion
        key_in   = A_K0;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (6) tick();
        kill = 1'b1;
        tick();
        chk("kill_valid", key_valid, 0);
        chk("kill_busy", busy, 0);
        chk("kill_round", key_round, 0);
        chk("kill_irq", irq, 0);
        kill = 1'b0;
        tick();

        // Serving inputs ignored while not READY
        for (int i = 0; i < 6; i++) begin
            key_ready = i[0];
            blk_start = i[1];
            tick();
        end
        key_ready = 1'b0;
        blk_start = 1'b0;
        chk("idle_round", key_round, 0);
        chk("idle_valid", key_valid, 0);
        load_wait(A_K0, lat);
        chk("idle_latency", 128'(lat), 41);
        chk("idle_rk0", key_round, A_K0);
        strobe(1);
        chk("idle_rk1", key_round, A_K1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
